img_reader: RTL and testbench

//  Streams an 8-bit image out of word-addressed memory, one pixel per handshake; the read-side counterpart of the image writer.

---
 rtl/dsa_img_pkg.sv | 23 ++
 rtl/img_reader_if.sv | 13 +
 rtl/img_word_fifo.sv | 63 ++++++
 rtl/img_reader.sv | 196 +++++++++++++++++++
 tb/tb_img_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsa_img_pkg.sv
// rtl/dsa_img_pkg.sv - shared types, constants and word-count helper for the image reader
package dsa_img_pkg;

  localparam int PIXEL_W      = 8;
  localparam int PIX_PER_WORD = 4;

  typedef logic [31:0]        word_t;
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } rd_state_e;

  // Words needed to cover len pixels; the 33-bit sum keeps len near 2^32 from wrapping.
  function automatic logic [30:0] words_for(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'(PIX_PER_WORD - 1);
    return 31'(sum >> $clog2(PIX_PER_WORD));
  endfunction

endpackage

// File: rtl/img_reader_if.sv
// rtl/img_reader_if.sv - pixel stream handshake bundle between img_reader and its consumer
interface img_reader_if;
  import dsa_img_pkg::*;

  logic   o_pix_valid;
  logic   i_pix_ready;
  pixel_t o_pix_data;
  logic   o_pix_last;

  modport master (output o_pix_valid, output o_pix_data, output o_pix_last, input i_pix_ready);
  modport slave  (input o_pix_valid, input o_pix_data, input o_pix_last, output i_pix_ready);

endinterface

// File: rtl/img_word_fifo.sv
// rtl/img_word_fifo.sv - word buffer for read prefetch, built only when IMG_READER_PREFETCH_EN is defined
`ifdef IMG_READER_PREFETCH_EN
module img_word_fifo
  import dsa_img_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  word_t                  push_data,
  input  logic                   pop,
  output word_t                  pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  word_t              mem_q [DEPTH];
  word_t              mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage and pointer registers, cleared on reset so no stale word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`endif

// File: rtl/img_reader.sv
// rtl/img_reader.sv - streams packed 8-bit pixels from word memory; IMG_READER_PREFETCH_EN adds a read-ahead word FIFO
module img_reader
  import dsa_img_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [31:0]       i_img_length,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  word_t             i_mem_rdata,
  img_reader_if.master      pix,
  output logic [31:0]       o_pix_count,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  rd_state_e         state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [30:0]       rd_left_q, rd_left_d;
  logic [31:0]       pix_left_q, pix_left_d;
  logic [31:0]       count_q, count_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  word_t             word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              unp_valid_q, unp_valid_d;

  logic  accept;
  logic  ret;
  logic  hs;
  logic  word_done;
  logic  unp_pop;
  logic  credit_ok;
  logic  issue;
  logic  load;
  word_t load_data;
  logic  unused_base_lsbs;

  // Base is word aligned internally; the low address bits carry no information.
  assign unused_base_lsbs = ^i_base_addr[1:0];

  // A read issued RD_LAT cycles ago is returning this cycle.
  assign ret       = pipe_q[RD_LAT-1];
  assign hs        = unp_valid_q && pix.i_pix_ready;
  // The held word is exhausted after byte 3 or after the image's final pixel.
  assign word_done = (idx_q == 2'd3) || (pix_left_q == 32'd1);
  assign unp_pop   = hs && word_done;

`ifdef IMG_READER_PREFETCH_EN
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  logic [FCNT_W-1:0] fifo_count;
  word_t             fifo_rdata;
  logic              fifo_pop;

  // Unpacker refills from the FIFO whenever it is empty or draining this cycle.
  assign fifo_pop  = (!unp_valid_q || unp_pop) && (fifo_count != '0);
  // Every outstanding read already owns a FIFO slot, so returns can always be pushed.
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
  assign load      = fifo_pop;
  assign load_data = fifo_rdata;

  img_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ret),
    .push_data (i_mem_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count)
  );
`else
  // Single-word capacity: the next read goes out only as the current word empties.
  assign credit_ok = (!unp_valid_q || unp_pop) && (inflight_q == '0);
  assign load      = ret;
  assign load_data = i_mem_rdata;
`endif

  assign issue = (state_q == RUN) && (rd_left_q != '0) && credit_ok;

  assign o_mem_re        = mem_re_q;
  assign o_mem_addr      = mem_addr_q;
  assign pix.o_pix_valid = unp_valid_q;
  assign pix.o_pix_data  = word_q[{idx_q, 3'b000} +: PIXEL_W];
  assign pix.o_pix_last  = unp_valid_q && (pix_left_q == 32'd1);
  assign o_pix_count     = count_q;
  assign o_busy          = (state_q == RUN);
  assign o_done          = (state_q == FINISH);

  // Control FSM: start acceptance, end of image on the final handshake, one-cycle done.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = (i_img_length == 32'd0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (hs && (pix_left_q == 32'd1)) begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: read issue, latency pipe, in-flight credit, unpacker and counters.
  always_comb begin
    mem_re_d    = issue;
    mem_addr_d  = mem_addr_q;
    next_addr_d = next_addr_q;
    rd_left_d   = rd_left_q;
    pix_left_d  = pix_left_q;
    count_d     = count_q;
    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(ret);
    pipe_d      = pipe_q << 1;
    pipe_d[0]   = mem_re_q;
    word_d      = word_q;
    idx_d       = idx_q;
    unp_valid_d = unp_valid_q;

    if (issue) begin
      mem_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(4);
      rd_left_d   = rd_left_q - 31'd1;
    end

    if (hs) begin
      idx_d      = idx_q + 2'd1;
      count_d    = count_q + 32'd1;
      pix_left_d = pix_left_q - 32'd1;
      if (word_done) begin
        unp_valid_d = 1'b0;
      end
    end

    if (load) begin
      word_d      = load_data;
      idx_d       = 2'd0;
      unp_valid_d = 1'b1;
    end

    if (accept) begin
      count_d     = 32'd0;
      next_addr_d = {i_base_addr[ADDR_W-1:2], 2'b00};
      pix_left_d  = i_img_length;
      rd_left_d   = words_for(i_img_length);
    end
  end

  // State register; reset abandons any image and drops returns still in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      next_addr_q <= '0;
      rd_left_q   <= '0;
      pix_left_q  <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      pipe_q      <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      unp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      next_addr_q <= next_addr_d;
      rd_left_q   <= rd_left_d;
      pix_left_q  <= pix_left_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      pipe_q      <= pipe_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      unp_valid_q <= unp_valid_d;
    end
  end

endmodule

// File: tb/tb_img_reader.sv
// tb/tb_img_reader.sv - scoreboard bench for img_reader
module tb_img_reader;
  import dsa_img_pkg::*;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_base_addr;
  logic [31:0] i_img_length;
  logic        o_mem_re;
  logic [15:0] o_mem_addr;
  word_t       i_mem_rdata;
  logic [31:0] o_pix_count;
  logic        o_busy;
  logic        o_done;

  img_reader_if pix_if();

  img_reader #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (2),
    .ADDR_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_img_length (i_img_length),
    .o_mem_re     (o_mem_re),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .pix          (pix_if),
    .o_pix_count  (o_pix_count),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n_reads = 0;
  int cyc_cnt = 0;
  int first_re_cyc = 0;
  bit first_re_seen = 0;
  bit first_valid_seen = 0;
  bit hold_pend = 0;
  logic [8:0] held;
  logic [8:0]  exp_pix[$];
  logic [15:0] exp_addr[$];

  // Memory contents: each byte holds the low 8 bits of its own address, except word 0x0304.
  function automatic word_t mem_word(input logic [15:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    if ({a[15:2], 2'b00} == 16'h0304) return 32'hDDCC_BBAA;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [7:0] pix_at(input logic [15:0] a);
    word_t w;
    w = mem_word(a);
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  word_t rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= o_mem_re ? mem_word(o_mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 1 event expected 0", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected reads/pixels and checks stall stability and first-pixel latency.
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (!rst_n) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          check("stall_valid", 32'(pix_if.o_pix_valid), 32'd1);
          check("stall_data_last", 32'({pix_if.o_pix_last, pix_if.o_pix_data}), 32'(held));
        end
        if (o_mem_re) begin
          n_reads++;
          if (!first_re_seen) begin
            first_re_seen = 1;
            first_re_cyc = cyc_cnt;
          end
          if (exp_addr.size() == 0) unexpected("extra_read");
          else check("rd_addr", 32'(o_mem_addr), 32'(exp_addr.pop_front()));
        end
        if (pix_if.o_pix_valid && !first_valid_seen && first_re_seen) begin
          first_valid_seen = 1;
          check("first_valid_latency", 32'((cyc_cnt - first_re_cyc) >= RD_LAT + 1), 32'd1);
        end
        if (pix_if.o_pix_valid && pix_if.i_pix_ready) begin
          if (exp_pix.size() == 0) unexpected("extra_pixel");
          else check("pixel_last_data", 32'({pix_if.o_pix_last, pix_if.o_pix_data}), 32'(exp_pix.pop_front()));
        end
        if (o_done) done_cnt++;
        hold_pend = pix_if.o_pix_valid && !pix_if.i_pix_ready;
        held = {pix_if.o_pix_last, pix_if.o_pix_data};
      end
    end
  end

  task automatic expect_image(input logic [15:0] base, input logic [31:0] len);
    logic [15:0] al;
    logic [15:0] a;
    int words;
    al = {base[15:2], 2'b00};
    words = int'((len + 32'd3) >> 2);
    for (int k = 0; k < int'(len); k++) begin
      a = al + 16'(k);
      exp_pix.push_back({(k == int'(len) - 1), pix_at(a)});
    end
    for (int w = 0; w < words; w++) exp_addr.push_back(al + 16'(4 * w));
    first_re_seen = 0;
    first_valid_seen = 0;
  endtask

  task automatic run_image(input logic [15:0] base, input logic [31:0] len, input bit rnd, input int poke);
    int d0;
    int r0;
    int cyc;
    expect_image(base, len);
    d0 = done_cnt;
    r0 = n_reads;
    i_base_addr = base;
    i_img_length = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("count_clear", o_pix_count, 32'd0);
    if (len == 0) begin
      check("zero_done_now", 32'(o_done), 32'd1);
      check("zero_busy", 32'(o_busy), 32'd0);
    end else begin
      check("busy_after_start", 32'(o_busy), 32'd1);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      pix_if.i_pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == poke) begin
        i_base_addr = 16'h1234;
        i_img_length = 32'd3;
        i_start = 1'b1;
      end
      tick();
      i_start = 1'b0;
      cyc++;
    end
    check("done_before_timeout", 32'(done_cnt != d0), 32'd1);
    tick();
    tick();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("read_count", 32'(n_reads - r0), (len + 32'd3) >> 2);
    check("pixels_left", 32'(exp_pix.size()), 32'd0);
    check("reads_left", 32'(exp_addr.size()), 32'd0);
    check("final_count", o_pix_count, len);
    check("busy_idle", 32'(o_busy), 32'd0);
    exp_pix.delete();
    exp_addr.delete();
    pix_if.i_pix_ready = 1'b1;
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_re"}, 32'(o_mem_re), 32'd0);
    check({nm, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({nm, "_valid"}, 32'(pix_if.o_pix_valid), 32'd0);
    check({nm, "_last"}, 32'(pix_if.o_pix_last), 32'd0);
    check({nm, "_data"}, 32'(pix_if.o_pix_data), 32'd0);
    check({nm, "_count"}, o_pix_count, 32'd0);
    check({nm, "_busy"}, 32'(o_busy), 32'd0);
    check({nm, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_img_length = '0;
    pix_if.i_pix_ready = 1'b1;
    #1;
    check_reset("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_image(16'h0100, 32'd8, 1'b0, -1);
    run_image(16'h0300, 32'd6, 1'b0, -1);
    run_image(16'h0200, 32'd0, 1'b0, -1);
    run_image(16'h0103, 32'd5, 1'b0, -1);
    run_image(16'h0600, 32'd37, 1'b1, 10);
    run_image(16'hFFF8, 32'd16, 1'b0, -1);

    expect_image(16'h0400, 32'd16);
    i_base_addr = 16'h0400;
    i_img_length = 32'd16;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (o_pix_count != 32'd5 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reach_pixel5", o_pix_count, 32'd5);
    rst_n = 1'b0;
    exp_pix.delete();
    exp_addr.delete();
    #1;
    check_reset("midreset");
    tick();
    rst_n = 1'b1;
    run_image(16'h0500, 32'd4, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
